// File: rtl/nf10_axis_pkt_gen_if.sv
// nf10_axis_pkt_gen_if: AXI4-Stream bundle between the packet generator and the 10G TX stream port.
interface nf10_axis_pkt_gen_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_pkt_gen.sv
// nf10_axis_pkt_gen: fixed-length AXI4-Stream frame generator with byte pattern and NetFPGA tuser; PKT_GEN_SEQNUM_EN puts a frame sequence number in word 0.
module nf10_axis_pkt_gen #(
  parameter int         C_M_AXIS_DATA_WIDTH  = 64,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_SRC_PORT           = 8'h00,
  parameter logic [7:0] C_DST_PORT           = 8'h01
) (
  input  logic                axi_aclk,
  input  logic                axi_resetn,
  input  logic                start,
  input  logic                stop,
  input  logic [15:0]         cfg_len,
  input  logic [15:0]         cfg_count,
  input  logic [7:0]          cfg_ifg,
  nf10_axis_pkt_gen_if.master m_axis,
  output logic                busy,
  output logic [31:0]         pkt_sent
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t      state, state_nx;
  logic [15:0] len_q, cnt_q, len_c;
  logic [7:0]  ifg_q, k, gap_cnt, last_k;
  logic        hs, done, end_run, accept;
`ifdef PKT_GEN_SEQNUM_EN
  logic [31:0] seq;
`endif
  // Length clamp, last-word index and frame-boundary decisions
  always_comb begin
    len_c   = cfg_len < 16'd60 ? 16'd60 : cfg_len > 16'd1518 ? 16'd1518 : cfg_len;
    last_k  = 8'((len_q + 16'd7) >> 3) - 8'd1;
    accept  = state == IDLE && start && !stop;
    hs      = state == SEND && m_axis.tready;
    done    = hs && k == last_k;
    end_run = stop || (cnt_q != 16'd0 && pkt_sent + 32'd1 == {16'd0, cnt_q});
  end
  // Next state; start enters GAP with a zero count so the first word appears one cycle later
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = accept ? GAP : IDLE;
    else if (state == SEND)
      state_nx = !done ? SEND : end_run ? IDLE : ifg_q == 8'd0 ? SEND : GAP;
    else
      state_nx = stop ? IDLE : gap_cnt == 8'd0 ? SEND : GAP;
  end
  // State register
  always_ff @(posedge axi_aclk or negedge axi_resetn)
    if (!axi_resetn) state <= IDLE;
    else             state <= state_nx;
  // Latched configuration, word index, frame counter and gap counter
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      len_q    <= '0;
      cnt_q    <= '0;
      ifg_q    <= '0;
      k        <= '0;
      gap_cnt  <= '0;
      pkt_sent <= '0;
    end else if (accept) begin
      len_q    <= len_c;
      cnt_q    <= cfg_count;
      ifg_q    <= cfg_ifg;
      k        <= '0;
      gap_cnt  <= '0;
      pkt_sent <= '0;
    end else if (hs) begin
      k <= done ? 8'd0 : k + 8'd1;
      if (done) begin
        pkt_sent <= pkt_sent + 32'd1;
        gap_cnt  <= ifg_q - 8'd1;
      end
    end else if (state == GAP && gap_cnt != 8'd0) begin
      gap_cnt <= gap_cnt - 8'd1;
    end
  end
`ifdef PKT_GEN_SEQNUM_EN
  // Frame sequence number, restarted by each accepted start
  always_ff @(posedge axi_aclk or negedge axi_resetn)
    if (!axi_resetn) seq <= '0;
    else if (accept) seq <= '0;
    else if (done)   seq <= seq + 32'd1;
`endif
  // Stream outputs are forced to zero outside SEND so reset and idle read all-zero
  always_comb begin
    m_axis.tvalid = state == SEND;
    busy          = state != IDLE;
    m_axis.tdata  = '0;
    for (int i = 0; i < C_M_AXIS_DATA_WIDTH / 8; i++)
      m_axis.tdata[8*i +: 8] = m_axis.tvalid ? {k[4:0], 3'(i)} : 8'd0;
`ifdef PKT_GEN_SEQNUM_EN
    if (m_axis.tvalid && k == 8'd0) m_axis.tdata[31:0] = seq;
`endif
    m_axis.tlast = m_axis.tvalid && k == last_k;
    m_axis.tstrb = !m_axis.tvalid ? 8'd0 :
                   m_axis.tlast && len_q[2:0] != 3'd0 ? 8'((9'd1 << len_q[2:0]) - 9'd1) : 8'hFF;
    m_axis.tuser = m_axis.tvalid ? {(C_M_AXIS_TUSER_WIDTH-32)'(0), C_DST_PORT, C_SRC_PORT, len_q} : '0;
  end
endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// tb_nf10_axis_pkt_gen: directed checks of frame pattern, clamping, back-pressure, gaps, stop and reset.
module tb_nf10_axis_pkt_gen;
  logic        axi_aclk = 0, axi_resetn = 0, start = 0, stop = 0;
  logic [15:0] cfg_len = 16'd64, cfg_count = 16'd1;
  logic [7:0]  cfg_ifg = 8'd0;
  logic        busy;
  logic [31:0] pkt_sent;
  int          n_vec = 0, n_bad = 0, cyc = 0;
  logic [63:0]  qd[$];
  logic [7:0]   qs[$];
  logic [127:0] qu[$];
  logic         ql[$];
  int           qc[$];
  logic [63:0]  pd;
  logic [7:0]   ps;
  logic [127:0] pu;
  logic         pl, pstall = 0;

  nf10_axis_pkt_gen_if axis ();

  nf10_axis_pkt_gen dut (
    .axi_aclk  (axi_aclk),
    .axi_resetn(axi_resetn),
    .start     (start),
    .stop      (stop),
    .cfg_len   (cfg_len),
    .cfg_count (cfg_count),
    .cfg_ifg   (cfg_ifg),
    .m_axis    (axis),
    .busy      (busy),
    .pkt_sent  (pkt_sent)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record handshaken words and check that stalled words are held
  always @(negedge axi_aclk) begin
    cyc <= cyc + 1;
    if (pstall) begin
      chk("hold_valid", axis.tvalid, 1'b1);
      chk("hold_data", axis.tdata, pd);
      chk("hold_strb", axis.tstrb, ps);
      chk("hold_user", axis.tuser, pu);
      chk("hold_last", axis.tlast, pl);
    end
    pstall <= axis.tvalid && !axis.tready;
    pd <= axis.tdata;
    ps <= axis.tstrb;
    pu <= axis.tuser;
    pl <= axis.tlast;
    if (axis.tvalid && axis.tready) begin
      qd.push_back(axis.tdata);
      qs.push_back(axis.tstrb);
      qu.push_back(axis.tuser);
      ql.push_back(axis.tlast);
      qc.push_back(cyc);
    end
  end

  task automatic go(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] ifg, input bit lat);
    qd.delete(); qs.delete(); qu.delete(); ql.delete(); qc.delete();
    @(posedge axi_aclk); #1;
    cfg_len = len; cfg_count = cnt; cfg_ifg = ifg; start = 1;
    @(posedge axi_aclk); #1;
    start = 0;
    if (lat) begin
      chk("lat_valid0", axis.tvalid, 1'b0);
      chk("lat_busy", busy, 1'b1);
      @(posedge axi_aclk); #1;
      chk("lat_valid1", axis.tvalid, 1'b1);
    end
  endtask

  task automatic wait_idle(input int max, input bit rnd);
    int i = 0;
    while (busy && i < max) begin
      @(posedge axi_aclk); #1;
      if (rnd) axis.tready = 1'($urandom_range(0, 1));
      i++;
    end
    axis.tready = 1;
    chk("timeout_idle", busy, 1'b0);
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (qd.size() < n && t < 500) begin
      @(negedge axi_aclk);
      t++;
    end
    chk("timeout_words", qd.size() >= n, 1'b1);
  endtask

  task automatic verify(input int len, input int n);
    int w;
    w = (len + 7) / 8;
    chk("nwords", qd.size(), w * n);
    for (int j = 0; j < w * n && j < qd.size(); j++) begin
      int f, k;
      logic [63:0] e;
      f = j / w;
      k = j % w;
      for (int i = 0; i < 8; i++) e[8*i +: 8] = 8'((8 * k + i) % 256);
`ifdef PKT_GEN_SEQNUM_EN
      if (k == 0) e[31:0] = 32'(f);
`endif
      chk("data", qd[j], e);
      chk("strb", qs[j], (k == w - 1 && len % 8 != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF);
      chk("last", ql[j], k == w - 1);
      chk("user", qu[j], {96'd0, 8'h01, 8'h00, 16'(len)});
    end
  endtask

  initial begin
    axis.tready = 1;
    repeat (3) @(posedge axi_aclk);
    #1;
    chk("rst_valid", axis.tvalid, 1'b0);
    chk("rst_data", axis.tdata, 64'd0);
    chk("rst_strb", axis.tstrb, 8'd0);
    chk("rst_user", axis.tuser, 128'd0);
    chk("rst_last", axis.tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent", pkt_sent, 32'd0);
    axi_resetn = 1;

    go(16'd64, 16'd2, 8'd0, 1);
    wait_idle(200, 0);
    verify(64, 2);
    chk("sent_2", pkt_sent, 32'd2);
    if (qc.size() == 16) begin
      chk("b2b", qc[8] - qc[7], 1);
      chk("no_bubble", qc[15] - qc[0], 15);
    end

    go(16'd61, 16'd1, 8'd0, 0);
    wait_idle(200, 0);
    verify(61, 1);
    if (qd.size() == 8) begin
      chk("strb_61", qs[7], 8'h1F);
      chk("byte_61", qd[7][7:0], 8'h38);
      chk("len_61", qu[0][15:0], 16'd61);
    end

    go(16'd20, 16'd1, 8'd0, 0);
    wait_idle(200, 0);
    verify(60, 1);
    go(16'd2000, 16'd1, 8'd0, 0);
    wait_idle(400, 0);
    verify(1518, 1);
    chk("words_1518", qd.size(), 190);

    go(16'd100, 16'd1, 8'd0, 0);
    wait_idle(3000, 1);
    verify(100, 1);

    go(16'd64, 16'd0, 8'd3, 0);
    wait_words(11);
    stop = 1;
    wait_idle(200, 0);
    stop = 0;
    verify(64, 2);
    chk("sent_stop", pkt_sent, 32'd2);
    if (qc.size() >= 9) chk("gap_3", qc[8] - qc[7], 4);
    @(posedge axi_aclk); #1;
    start = 1; stop = 1;
    @(posedge axi_aclk); #1;
    start = 0; stop = 0;
    chk("startstop_busy", busy, 1'b0);
    @(posedge axi_aclk); #1;
    chk("startstop_valid", axis.tvalid, 1'b0);
    chk("startstop_sent", pkt_sent, 32'd2);

    go(16'd64, 16'd0, 8'd0, 0);
    wait_words(4);
    @(posedge axi_aclk); #2;
    axi_resetn = 0;
    #1;
    chk("arst_valid", axis.tvalid, 1'b0);
    chk("arst_data", axis.tdata, 64'd0);
    chk("arst_last", axis.tlast, 1'b0);
    chk("arst_user", axis.tuser, 128'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_sent", pkt_sent, 32'd0);
    @(posedge axi_aclk); #1;
    axi_resetn = 1;
    @(posedge axi_aclk); #1;
    chk("post_rst_idle", busy, 1'b0);
    go(16'd64, 16'd2, 8'd0, 0);
    wait_idle(200, 0);
    verify(64, 2);
    chk("sent_post_rst", pkt_sent, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
